// File: rtl/timebase_pkg.sv
// Shared types and width helpers for the digital-clock timebase controller.
package timebase_pkg;

   // Run/pause/step sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } tbState_e;

   // Bits needed to hold a counter that ranges 0..n-1 (never narrower than 1 bit)
   function automatic int cntWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/timebase_ctrl_if.sv
// Front-panel keys, commands and timebase enables exchanged with the time and display logic.
interface timebase_ctrl_if
   import timebase_pkg::*;
#(
   parameter int DIGITS = 8
);

   localparam int SEL_W = cntWidth(DIGITS);

   logic             key_run;
   logic             key_step;
   logic             clr_time;
   logic             scan_en;
   logic             sec_en;
   logic [SEL_W-1:0] scan_sel;
   logic             running;
   logic             blink;

   // Board / surrounding logic side: drives keys and commands, observes enables
   modport master (
      output key_run, key_step, clr_time,
      input  scan_en, sec_en, scan_sel, running, blink
   );

   // Controller side
   modport slave (
      input  key_run, key_step, clr_time,
      output scan_en, sec_en, scan_sel, running, blink
   );

endinterface

// File: rtl/key_debounce.sv
// One front-panel key: two-flop synchroniser, sample-count debounce on a shared
// strobe, and a single-cycle pulse on each accepted press.
module key_debounce
   import timebase_pkg::*;
#(
   parameter int DEB_TICKS = 20
) (
   input  logic CP,
   input  logic CLR_n,
   input  logic key_i,
   input  logic sample_i,
   output logic press_o
);

   localparam int CNT_W = cntWidth(DEB_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

   logic             sync1_q, sync2_q;
   logic             lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q;

   // Bring the asynchronous key into the CP domain
   always_ff @(posedge CP) begin
      if (CLR_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after DEB_TICKS consecutive samples disagree with the current one
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      if (sample_i) begin
         if (sync2_q == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            lvl_d = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounced level, run length, and a one-cycle pulse when the level rises
   always_ff @(posedge CP) begin
      if (CLR_n) begin
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         press_q <= lvl_d & ~lvl_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/timebase_ctrl.sv
// Run/pause/step timebase for the digital clock: scan-rate prescaler, digit
// select, blink flag, sub-second counter and the seconds enable, all as
// single-cycle enables on CP.
module timebase_ctrl
   import timebase_pkg::*;
#(
   parameter int CLK_HZ    = 100000,
   parameter int SCAN_HZ   = 1000,
   parameter int DIGITS    = 8,
   parameter int DEB_TICKS = 20
) (
   input  logic            CP,
   input  logic            CLR_n,
   timebase_ctrl_if.slave  bus
);

   // SCAN_DIV must divide CLK_HZ exactly and be at least 2
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int BL_HALF  = SCAN_HZ / 2;

   localparam int PRE_W = cntWidth(SCAN_DIV);
   localparam int MS_W  = cntWidth(SCAN_HZ);
   localparam int BL_W  = cntWidth(BL_HALF);
   localparam int SEL_W = cntWidth(DIGITS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(SCAN_HZ - 1);
   localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BL_HALF - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

   logic [PRE_W-1:0] pre_q;
   logic             scan_q;
   logic [SEL_W-1:0] sel_q;
   logic [BL_W-1:0]  blink_cnt_q;
   logic             blink_q;

   tbState_e         state_q, state_d;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic             sec_q, sec_d;
   logic             running_q;

   logic             runPress;
   logic             stepPress;

   // Free-running prescaler; scan_en is the registered terminal count
   always_ff @(posedge CP) begin
      if (CLR_n) begin
         pre_q  <= '0;
         scan_q <= 1'b0;
      end else begin
         scan_q <= (pre_q == PRE_LAST);
         pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      end
   end

   // Digit select and blink divider advance on every scan strobe regardless of state
   always_ff @(posedge CP) begin
      if (CLR_n) begin
         sel_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else if (scan_q) begin
         sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
         if (blink_cnt_q == BL_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   key_debounce #(.DEB_TICKS(DEB_TICKS)) uRunKey (
      .CP       (CP),
      .CLR_n    (CLR_n),
      .key_i    (bus.key_run),
      .sample_i (scan_q),
      .press_o  (runPress)
   );

   key_debounce #(.DEB_TICKS(DEB_TICKS)) uStepKey (
      .CP       (CP),
      .CLR_n    (CLR_n),
      .key_i    (bus.key_step),
      .sample_i (scan_q),
      .press_o  (stepPress)
   );

   // Sequencing: clr_time beats run, run beats step; natural ticks only in RUN, steps only outside it
   always_comb begin
      state_d = state_q;
      ms_d    = ms_q;
      sec_d   = 1'b0;
      if (bus.clr_time) begin
         state_d = IDLE;
         ms_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (runPress) begin
                  state_d = RUN;
                  ms_d    = '0;
               end else if (stepPress) begin
                  sec_d = 1'b1;
               end
            end
            RUN: begin
               if (runPress) begin
                  state_d = PAUSE;
               end else if (scan_q) begin
                  if (ms_q == MS_LAST) begin
                     ms_d  = '0;
                     sec_d = 1'b1;
                  end else begin
                     ms_d = ms_q + 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (runPress) begin
                  state_d = RUN;
               end else if (stepPress) begin
                  sec_d = 1'b1;
                  ms_d  = '0;
               end
            end
            default: begin
               state_d = IDLE;
               ms_d    = '0;
            end
         endcase
      end
   end

   // State, sub-second count and the registered sec_en / running outputs
   always_ff @(posedge CP) begin
      if (CLR_n) begin
         state_q   <= IDLE;
         ms_q      <= '0;
         sec_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ms_q      <= ms_d;
         sec_q     <= sec_d;
         running_q <= (state_d == RUN);
      end
   end

   assign bus.scan_en  = scan_q;
   assign bus.sec_en   = sec_q;
   assign bus.scan_sel = sel_q;
   assign bus.running  = running_q;
   assign bus.blink    = blink_q;

endmodule
